// File: rtl/fir_filter_mc.sv
// Time-multiplexed multi-channel FIR filter.
// Each channel has its own circular delay line and head pointer. One shared MAC unit
// walks the taps of the accepted channel, then the sum is rounded, saturated and tagged.
module fir_filter_mc #(
    parameter int unsigned DATA_W   = 18,
    parameter int unsigned COEF_W   = 18,
    parameter int unsigned TAPS     = 16,
    parameter int unsigned CHANNELS = 2,
    parameter int unsigned CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
    parameter int unsigned ACC_W    = DATA_W + COEF_W + $clog2(TAPS)
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [DATA_W-1:0]               inSignalUnReg,
    input  logic [CH_W-1:0]                 inChannel,
    input  logic                            newData,
    output logic                            inReady,
    input  logic                            coefWe,
    input  logic [CH_W+$clog2(TAPS)-1:0]    coefAddr,
    input  logic [COEF_W-1:0]               coefData,
    output logic [DATA_W-1:0]               outSignal,
    output logic [CH_W-1:0]                 outChannel,
    output logic                            dataReady,
    output logic                            overrun
);

    localparam int unsigned TAP_W  = $clog2(TAPS);
    localparam int unsigned AW     = CH_W + TAP_W;
    localparam int unsigned DEPTH  = 2 ** AW;
    localparam int unsigned PROD_W = DATA_W + COEF_W;

    localparam logic [AW-1:0]    CLR_LAST = AW'(CHANNELS * TAPS - 1);
    localparam logic [TAP_W-1:0] TAP_LAST = TAP_W'(TAPS - 1);

    // Half an LSB of the output in Q1.(COEF_W-1) scaling.
    localparam logic signed [ACC_W-1:0] RND_C =
        {{(ACC_W - COEF_W + 1){1'b0}}, 1'b1, {(COEF_W - 2){1'b0}}};
    localparam logic signed [ACC_W-1:0] SAT_MAX =
        {{(ACC_W - DATA_W + 1){1'b0}}, {(DATA_W - 1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN =
        {{(ACC_W - DATA_W + 1){1'b1}}, {(DATA_W - 1){1'b0}}};

    typedef enum logic [2:0] {
        StClear,
        StIdle,
        StLoad,
        StMac,
        StRound,
        StOut
    } state_t;

    state_t state_q, state_d;
    logic [AW-1:0] cnt_q, cnt_d;

    logic signed [DATA_W-1:0] sample_q;
    logic [CH_W-1:0]          ch_q;
    logic [TAP_W-1:0]         head_q [2**CH_W];
    logic signed [ACC_W-1:0]  acc_q;
    logic signed [DATA_W-1:0] res_q;

    logic signed [DATA_W-1:0] dline [DEPTH];
    logic signed [COEF_W-1:0] coef  [DEPTH];

    logic                     ch_valid;
    logic                     accept;
    logic [TAP_W-1:0]         tap_k;
    logic [TAP_W-1:0]         rd_idx;
    logic signed [DATA_W-1:0] x_sel;
    logic signed [COEF_W-1:0] c_sel;
    logic signed [PROD_W-1:0] prod;
    logic signed [ACC_W-1:0]  acc_add;
    logic signed [ACC_W-1:0]  rnd;
    logic signed [ACC_W-1:0]  shf;
    logic signed [DATA_W-1:0] sat;

    // Channel range check only needed when CHANNELS does not fill the index space.
    if (2 ** CH_W == CHANNELS) begin : g_all_valid
        assign ch_valid = 1'b1;
    end else begin : g_range_check
        assign ch_valid = 32'(inChannel) < CHANNELS;
    end

    assign inReady = (state_q == StIdle);
    assign accept  = inReady && newData && ch_valid;

    assign tap_k   = cnt_q[TAP_W-1:0];
    assign rd_idx  = head_q[ch_q] - tap_k;
    assign x_sel   = dline[{ch_q, rd_idx}];
    assign c_sel   = coef[{ch_q, tap_k}];
    assign prod    = $signed({{COEF_W{x_sel[DATA_W-1]}}, x_sel})
                   * $signed({{DATA_W{c_sel[COEF_W-1]}}, c_sel});
    assign acc_add = acc_q + $signed({{(ACC_W - PROD_W){prod[PROD_W-1]}}, prod});
    assign rnd     = acc_q + RND_C;
    assign shf     = rnd >>> (COEF_W - 1);

    // Clamp the rounded sum into the output range.
    always_comb begin
        sat = shf[DATA_W-1:0];
        if (shf > SAT_MAX) begin
            sat = {1'b0, {(DATA_W - 1){1'b1}}};
        end else if (shf < SAT_MIN) begin
            sat = {1'b1, {(DATA_W - 1){1'b0}}};
        end
    end

    // State and shared counter (CLEAR walk address, then MAC tap index).
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StClear;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            StClear: begin
                cnt_d = cnt_q + AW'(1);
                if (cnt_q == CLR_LAST) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end
            end
            StIdle: begin
                if (accept) begin
                    state_d = StLoad;
                end
            end
            StLoad: begin
                cnt_d   = '0;
                state_d = StMac;
            end
            StMac: begin
                cnt_d = cnt_q + AW'(1);
                if (tap_k == TAP_LAST) begin
                    state_d = StRound;
                end
            end
            StRound: state_d = StOut;
            StOut:   state_d = StIdle;
            default: state_d = StClear;
        endcase
    end

    // Datapath registers, head pointers and the output/status flags.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sample_q   <= '0;
            ch_q       <= '0;
            acc_q      <= '0;
            res_q      <= '0;
            outSignal  <= '0;
            outChannel <= '0;
            dataReady  <= 1'b0;
            overrun    <= 1'b0;
            for (int i = 0; i < 2 ** CH_W; i++) begin
                head_q[i] <= '0;
            end
        end else begin
            dataReady <= 1'b0;
            if (accept) begin
                sample_q <= inSignalUnReg;
                ch_q     <= inChannel;
            end
            if (newData && !inReady) begin
                overrun <= 1'b1;
            end
            case (state_q)
                StLoad:  acc_q <= '0;
                StMac: begin
                    acc_q <= acc_add;
                    if (tap_k == TAP_LAST) begin
                        head_q[ch_q] <= head_q[ch_q] + TAP_W'(1);
                    end
                end
                StRound: res_q <= sat;
                StOut: begin
                    outSignal  <= res_q;
                    outChannel <= ch_q;
                    dataReady  <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Delay-line and coefficient storage; coefficients deliberately survive reset.
    always_ff @(posedge clk) begin
        if (state_q == StClear) begin
            dline[cnt_q] <= '0;
        end
        if (state_q == StLoad) begin
            dline[{ch_q, head_q[ch_q]}] <= sample_q;
        end
        if (coefWe && state_q == StIdle) begin
            coef[coefAddr] <= coefData;
        end
    end

endmodule

// File: tb/tb_fir_filter_mc.sv
// Self-checking bench for fir_filter_mc: hand-derived vector tables for the
// documented corner cases plus randomized traffic against a shift-register model.
module tb_fir_filter_mc;

    localparam int DATA_W   = 18;
    localparam int COEF_W   = 18;
    localparam int TAPS     = 16;
    localparam int CHANNELS = 2;
    localparam int CH_W     = 1;
    localparam int TAP_W    = 4;
    localparam int AW       = CH_W + TAP_W;
    localparam longint DMAX = (longint'(1) <<< (DATA_W - 1)) - 1;
    localparam longint DMIN = -(longint'(1) <<< (DATA_W - 1));

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [DATA_W-1:0] inSignalUnReg = '0;
    logic [CH_W-1:0]   inChannel = '0;
    logic              newData = 1'b0;
    logic              inReady;
    logic              coefWe = 1'b0;
    logic [AW-1:0]     coefAddr = '0;
    logic [COEF_W-1:0] coefData = '0;
    logic [DATA_W-1:0] outSignal;
    logic [CH_W-1:0]   outChannel;
    logic              dataReady;
    logic              overrun;

    fir_filter_mc #(
        .DATA_W  (DATA_W),
        .COEF_W  (COEF_W),
        .TAPS    (TAPS),
        .CHANNELS(CHANNELS)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .inSignalUnReg(inSignalUnReg),
        .inChannel    (inChannel),
        .newData      (newData),
        .inReady      (inReady),
        .coefWe       (coefWe),
        .coefAddr     (coefAddr),
        .coefData     (coefData),
        .outSignal    (outSignal),
        .outChannel   (outChannel),
        .dataReady    (dataReady),
        .overrun      (overrun)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: coefficient table and per-channel history, index 0 = newest.
    longint mcoef [CHANNELS][TAPS];
    longint mhist [CHANNELS][TAPS];
    longint exp_val;
    int     exp_ch;
    int     e0;

    typedef struct {
        int ch;
        int x;
        int y;
    } vec_t;

    vec_t imp_tbl [5];
    vec_t iso_tbl [3];
    vec_t sat_tbl [4];
    vec_t rnd_tbl [2];

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    function automatic longint sext(input logic [DATA_W-1:0] v);
        return longint'($signed(v));
    endfunction

    task automatic model_clear();
        for (int c = 0; c < CHANNELS; c++)
            for (int k = 0; k < TAPS; k++) mhist[c][k] = 0;
    endtask

    // Shift the sample into the channel history and compute the rounded, clamped dot product.
    task automatic model_accept(input int ch, input longint x, output longint y);
        longint sum;
        for (int k = TAPS - 1; k > 0; k--) mhist[ch][k] = mhist[ch][k-1];
        mhist[ch][0] = x;
        sum = 0;
        for (int k = 0; k < TAPS; k++) sum += mcoef[ch][k] * mhist[ch][k];
        y = (sum + (longint'(1) <<< (COEF_W - 2))) >>> (COEF_W - 1);
        if (y > DMAX) y = DMAX;
        if (y < DMIN) y = DMIN;
    endtask

    task automatic wait_ready();
        int n;
        n = 0;
        @(negedge clk);
        while (!inReady && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!inReady) check("ready_timeout", longint'(inReady), 1);
    endtask

    task automatic write_coef(input int ch, input int tap, input int val);
        wait_ready();
        coefWe   = 1'b1;
        coefAddr = AW'(ch * TAPS + tap);
        coefData = COEF_W'(val);
        @(negedge clk);
        coefWe = 1'b0;
        mcoef[ch][tap] = val;
    endtask

    task automatic start(input int ch, input int x, input bit we, input int wtap, input int wval);
        wait_ready();
        inChannel     = CH_W'(ch);
        inSignalUnReg = DATA_W'(x);
        newData       = 1'b1;
        if (we) begin
            coefWe   = 1'b1;
            coefAddr = AW'(ch * TAPS + wtap);
            coefData = COEF_W'(wval);
            mcoef[ch][wtap] = wval;
        end
        @(negedge clk);
        newData = 1'b0;
        coefWe  = 1'b0;
        e0      = cyc;
        exp_ch  = ch;
        model_accept(ch, longint'(x), exp_val);
    endtask

    task automatic finish(input string tag);
        int n;
        n = 0;
        while (!dataReady && n < TAPS + 10) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_lat"}, longint'(cyc - e0), TAPS + 3);
        check({tag, "_val"}, sext(outSignal), exp_val);
        check({tag, "_ch"}, longint'(outChannel), exp_ch);
        check({tag, "_rdy"}, longint'(inReady), 1);
        @(negedge clk);
        check({tag, "_pulse"}, longint'(dataReady), 0);
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        start(v.ch, v.x, 1'b0, 0, 0);
        finish(tag);
        check({tag, "_tbl"}, sext(outSignal), v.y);
    endtask

    task automatic release_and_count(input string tag);
        int n;
        bit dr_seen;
        n = 0;
        dr_seen = 1'b0;
        rst = 1'b1;
        while (!inReady && n < 100) begin
            @(negedge clk);
            if (dataReady) dr_seen = 1'b1;
            n++;
        end
        check({tag, "_clear_len"}, n, CHANNELS * TAPS);
        check({tag, "_no_out"}, longint'(dr_seen), 0);
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1);
    end

    initial begin
        imp_tbl[0] = '{0, 400, 100};
        imp_tbl[1] = '{0, 0, 100};
        imp_tbl[2] = '{0, 0, 100};
        imp_tbl[3] = '{0, 0, 100};
        imp_tbl[4] = '{0, 0, 0};
        iso_tbl[0] = '{1, 400, 100};
        iso_tbl[1] = '{0, 0, 0};
        iso_tbl[2] = '{1, 0, 100};
        sat_tbl[0] = '{0, 131071, 131070};
        sat_tbl[1] = '{0, 131071, 131071};
        sat_tbl[2] = '{0, -131072, -1};
        sat_tbl[3] = '{0, -131072, -131072};
        rnd_tbl[0] = '{0, 3, 2};
        rnd_tbl[1] = '{0, -3, -1};
        model_clear();

        // Reset state and CLEAR length.
        repeat (3) @(negedge clk);
        check("rst_inReady", longint'(inReady), 0);
        check("rst_outSignal", sext(outSignal), 0);
        check("rst_outChannel", longint'(outChannel), 0);
        check("rst_dataReady", longint'(dataReady), 0);
        check("rst_overrun", longint'(overrun), 0);
        release_and_count("por");

        // Impulse coefficients on both channels.
        for (int c = 0; c < CHANNELS; c++)
            for (int k = 0; k < TAPS; k++) write_coef(c, k, (k < 4) ? 32768 : 0);
        foreach (imp_tbl[i]) run_vec(imp_tbl[i], $sformatf("imp%0d", i));
        foreach (iso_tbl[i]) run_vec(iso_tbl[i], $sformatf("iso%0d", i));

        // Saturation, then round-half-up.
        write_coef(0, 0, 131071);
        write_coef(0, 1, 131071);
        write_coef(0, 2, 0);
        write_coef(0, 3, 0);
        foreach (sat_tbl[i]) run_vec(sat_tbl[i], $sformatf("sat%0d", i));
        write_coef(0, 0, 65536);
        write_coef(0, 1, 0);
        foreach (rnd_tbl[i]) run_vec(rnd_tbl[i], $sformatf("rnd%0d", i));

        // Sample and coefficient write during MAC are both ignored; overrun sticks.
        start(0, 500, 1'b0, 0, 0);
        repeat (4) @(negedge clk);
        newData       = 1'b1;
        inSignalUnReg = DATA_W'(12345);
        inChannel     = '0;
        coefWe        = 1'b1;
        coefAddr      = '0;
        coefData      = COEF_W'(777);
        @(negedge clk);
        newData = 1'b0;
        coefWe  = 1'b0;
        check("ovr_flag", longint'(overrun), 1);
        finish("ovr");
        start(0, -250, 1'b0, 0, 0);
        finish("ovr_next");
        check("ovr_sticky", longint'(overrun), 1);

        // Coefficient write and sample in the same IDLE cycle: new coefficient applies.
        start(1, 1000, 1'b1, 0, 98304);
        finish("we_nd");
        check("we_nd_tbl", sext(outSignal), 850);

        // Randomized traffic against the model.
        for (int c = 0; c < CHANNELS; c++)
            for (int k = 0; k < TAPS; k++)
                write_coef(c, k, int'($urandom_range(262143)) - 131072);
        for (int i = 0; i < 40; i++) begin
            int ch;
            bit we;
            ch = int'($urandom_range(CHANNELS - 1));
            we = ($urandom_range(7) == 0);
            start(ch, int'($urandom_range(262143)) - 131072, we,
                  int'($urandom_range(TAPS - 1)), int'($urandom_range(262143)) - 131072);
            finish($sformatf("rnd_traffic%0d", i));
        end

        // Mid-operation reset: in-flight sample lost, coefficients kept, history zeroed.
        for (int k = 0; k < TAPS; k++) write_coef(0, k, (k < 4) ? 32768 : 0);
        for (int i = 0; i < 3; i++) begin
            start(0, int'($urandom_range(20000)) - 10000, 1'b0, 0, 0);
            finish($sformatf("pre_rst%0d", i));
        end
        start(0, 777, 1'b0, 0, 0);
        repeat (6) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("mid_rst_dataReady", longint'(dataReady), 0);
        check("mid_rst_inReady", longint'(inReady), 0);
        check("mid_rst_outSignal", sext(outSignal), 0);
        check("mid_rst_overrun", longint'(overrun), 0);
        repeat (2) @(negedge clk);
        model_clear();
        release_and_count("mid");
        foreach (imp_tbl[i]) run_vec(imp_tbl[i], $sformatf("imp_again%0d", i));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
